// File: rtl/hook_pkg.sv
// ---------------------------------------------------------------------------
// hook_pkg
// Shared definitions for the claw/hook controller and the object modules
// that respond to it.
//   hook_state_t : 3-bit controller state, encodings visible on state_out
//   HOOK_DX/DY   : per-angle extension vector, indexed by R_mode 0..10
//   SCREEN_*_PX  : playfield size shared with the object modules
// ---------------------------------------------------------------------------
package hook_pkg;

    typedef enum logic [2:0] {
        SWING          = 3'd0,
        EXTEND         = 3'd1,
        RETRACT        = 3'd2,
        RETRACT_LOADED = 3'd3,
        RETURN         = 3'd4
    } hook_state_t;

    localparam logic [9:0] SCREEN_W_PX = 10'd640;
    localparam logic [9:0] SCREEN_H_PX = 10'd480;

    // Largest legal angle index; the swing ping-pongs between 0 and this.
    localparam logic [3:0] R_MODE_MAX = 4'd10;

    // Extension step per angle index, left (0) through straight down (5)
    // to right (10).
    localparam logic signed [3:0] HOOK_DX [0:10] = '{
        -4'sd6, -4'sd6, -4'sd5, -4'sd4, -4'sd2, 4'sd0,
         4'sd2,  4'sd4,  4'sd5,  4'sd6,  4'sd6
    };
    localparam logic signed [3:0] HOOK_DY [0:10] = '{
         4'sd0,  4'sd1,  4'sd2,  4'sd3,  4'sd4, 4'sd6,
         4'sd4,  4'sd3,  4'sd2,  4'sd1,  4'sd0
    };

    // Table lookups that stay defined for the unused codes 11..15.
    function automatic logic signed [3:0] pick_dx(input logic [3:0] m);
        logic signed [3:0] r;
        r = 4'sd0;
        if (m <= R_MODE_MAX) r = HOOK_DX[m];
        return r;
    endfunction

    function automatic logic signed [3:0] pick_dy(input logic [3:0] m);
        logic signed [3:0] r;
        r = 4'sd0;
        if (m <= R_MODE_MAX) r = HOOK_DY[m];
        return r;
    endfunction

    // Sign-extend a table entry into the 12-bit position arithmetic.
    function automatic logic signed [11:0] ext_vec(input logic signed [3:0] v);
        return {{8{v[3]}}, v};
    endfunction

endpackage

// File: rtl/hook_tick_div.sv
// ---------------------------------------------------------------------------
// hook_tick_div
// Free-running clock divider producing a one-cycle tick every DIV enabled
// clocks. A synchronous clear restarts the count so a fresh state always
// gets a full period before its first tick.
//   clk    in  : system clock
//   rst_n  in  : asynchronous active-low reset
//   clear  in  : synchronous restart, also suppresses the tick this cycle
//   enable in  : count only while high (count is held at zero otherwise)
//   tick   out : high for one cycle when the count reaches DIV-1
// ---------------------------------------------------------------------------
module hook_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // The tick is masked by clear so a state change never also consumes
    // a step on the same edge.
    assign tick = enable && !clear && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hook_claw_ctrl.sv
// ---------------------------------------------------------------------------
// hook_claw_ctrl
// Claw/hook controller for one player. Swings an angle index 0..10, fires
// the hook outward on request, latches a catch reported by the objects and
// reels back at loaded or empty speed, pulsing score_pulse on a loaded
// return. One instance per player.
//
// Ports
//   Clk               in   system clock
//   reset_n           in   asynchronous active-low reset
//   is_new_game_start in   synchronous clear back to the post-reset state
//   fire              in   launch request (level, only honoured in SWING)
//   is_catch          in   OR of this player's catch flags from all objects
//   use_bomb          in   (HOOK_BOMB_EN only) blow up the carried object
//   tailx, taily      out  hook tail coordinates (10 bits each)
//   R_mode            out  angle index 0..10
//   state_out         out  state encoding (see hook_pkg::hook_state_t)
//   score_pulse       out  one-cycle pulse on a loaded return
//   is_explode        out  (HOOK_BOMB_EN only) one-cycle bomb pulse
//   busy              out  high whenever the hook is not swinging
//
// Build option
//   HOOK_BOMB_EN : adds use_bomb/is_explode and a two-shot bomb counter
//                  that lets a loaded retract drop its object and finish
//                  at empty speed.
// ---------------------------------------------------------------------------
module hook_claw_ctrl
    import hook_pkg::*;
#(
    parameter logic [9:0] ORIGIN_X  = 10'd320,
    parameter logic [9:0] ORIGIN_Y  = 10'd60,
    parameter logic [9:0] SCREEN_W  = SCREEN_W_PX,
    parameter logic [9:0] SCREEN_H  = SCREEN_H_PX,
    parameter int         SWING_DIV = 5000000,
    parameter int         STEP_DIV  = 1000000,
    parameter int         LOAD_DIV  = 8000000,
    parameter logic [9:0] MAX_STEPS = 10'd70
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       is_new_game_start,
    input  logic       fire,
    input  logic       is_catch,
`ifdef HOOK_BOMB_EN
    input  logic       use_bomb,
    output logic       is_explode,
`endif
    output logic [9:0] tailx,
    output logic [9:0] taily,
    output logic [3:0] R_mode,
    output logic [2:0] state_out,
    output logic       score_pulse,
    output logic       busy
);

    hook_state_t state;
    hook_state_t state_next;

    logic [9:0]  n;
    logic        dir_up;
    logic [3:0]  swing_next;
    logic        dir_next;

    logic        div_clear;
    logic        swing_en;
    logic        step_en;
    logic        load_en;
    logic        swing_tick;
    logic        step_tick;
    logic        load_tick;

    logic signed [11:0] dx12;
    logic signed [11:0] dy12;
    logic signed [11:0] n12;
    logic signed [11:0] n_next12;
    logic signed [11:0] cur_x;
    logic signed [11:0] cur_y;
    logic signed [11:0] nxt_x;
    logic signed [11:0] nxt_y;
    logic               out_of_bounds;

`ifdef HOOK_BOMB_EN
    logic [1:0] bomb_count;
    logic       bomb_fire;
`endif

    // ------------------------------------------------------------------
    // Geometry: current tail position (registered below) and the position
    // one step further out, used to stop before leaving the screen.
    // ------------------------------------------------------------------
    assign dx12     = ext_vec(pick_dx(R_mode));
    assign dy12     = ext_vec(pick_dy(R_mode));
    assign n12      = $signed({2'b00, n});
    assign n_next12 = n12 + 12'sd1;
    assign cur_x    = $signed({2'b00, ORIGIN_X}) + n12 * dx12;
    assign cur_y    = $signed({2'b00, ORIGIN_Y}) + n12 * dy12;
    assign nxt_x    = $signed({2'b00, ORIGIN_X}) + n_next12 * dx12;
    assign nxt_y    = $signed({2'b00, ORIGIN_Y}) + n_next12 * dy12;

    assign out_of_bounds = (nxt_x < 12'sd0) || (nxt_x >= $signed({2'b00, SCREEN_W})) ||
                           (nxt_y < 12'sd0) || (nxt_y >= $signed({2'b00, SCREEN_H}));

    // ------------------------------------------------------------------
    // Next-state logic. A catch outranks the boundary stop so an object
    // grabbed on the last legal step is still reeled in.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
`ifdef HOOK_BOMB_EN
        bomb_fire  = 1'b0;
`endif
        case (state)
            SWING: begin
                if (fire) state_next = EXTEND;
            end
            EXTEND: begin
                if (is_catch) begin
                    state_next = RETRACT_LOADED;
                end else if ((n == MAX_STEPS) || out_of_bounds) begin
                    state_next = RETRACT;
                end
            end
            RETRACT: begin
                if (n == 10'd0) state_next = RETURN;
            end
            RETRACT_LOADED: begin
                if (n == 10'd0) begin
                    state_next = RETURN;
                end
`ifdef HOOK_BOMB_EN
                else if (use_bomb && (bomb_count != 2'd0)) begin
                    state_next = RETRACT;
                    bomb_fire  = 1'b1;
                end
`endif
            end
            RETURN: begin
                state_next = SWING;
            end
            default: begin
                state_next = SWING;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Swing stepping: move one index in the current direction and turn
    // around on reaching either end so the index never leaves 0..10.
    // ------------------------------------------------------------------
    always_comb begin
        if (dir_up) begin
            swing_next = (R_mode >= R_MODE_MAX) ? (R_MODE_MAX - 4'd1) : (R_mode + 4'd1);
        end else begin
            swing_next = (R_mode == 4'd0) ? 4'd1 : (R_mode - 4'd1);
        end
        dir_next = dir_up;
        if (swing_next == R_MODE_MAX) begin
            dir_next = 1'b0;
        end else if (swing_next == 4'd0) begin
            dir_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Dividers restart on every state change so each state's first step
    // takes a full period.
    // ------------------------------------------------------------------
    assign div_clear = is_new_game_start || (state_next != state);
    assign swing_en  = (state == SWING);
    assign step_en   = (state == EXTEND) || (state == RETRACT);
    assign load_en   = (state == RETRACT_LOADED);

    hook_tick_div #(.DIV(SWING_DIV)) u_swing_div (
        .clk    (Clk),
        .rst_n  (reset_n),
        .clear  (div_clear),
        .enable (swing_en),
        .tick   (swing_tick)
    );

    hook_tick_div #(.DIV(STEP_DIV)) u_step_div (
        .clk    (Clk),
        .rst_n  (reset_n),
        .clear  (div_clear),
        .enable (step_en),
        .tick   (step_tick)
    );

    // The loaded rate must match the objects' pull divider so the tail
    // and the carried object move in lockstep.
    hook_tick_div #(.DIV(LOAD_DIV)) u_load_div (
        .clk    (Clk),
        .rst_n  (reset_n),
        .clear  (div_clear),
        .enable (load_en),
        .tick   (load_tick)
    );

    // ------------------------------------------------------------------
    // State, step count, swing angle and score pulse. A new game behaves
    // exactly like reset and overrides everything else.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SWING;
            n           <= 10'd0;
            R_mode      <= 4'd5;
            dir_up      <= 1'b1;
            score_pulse <= 1'b0;
        end else if (is_new_game_start) begin
            state       <= SWING;
            n           <= 10'd0;
            R_mode      <= 4'd5;
            dir_up      <= 1'b1;
            score_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            score_pulse <= (state == RETRACT_LOADED) && (state_next == RETURN);
            if (swing_tick) begin
                R_mode <= swing_next;
                dir_up <= dir_next;
            end
            case (state)
                EXTEND: begin
                    if (step_tick) n <= n + 10'd1;
                end
                RETRACT: begin
                    if (step_tick && (n != 10'd0)) n <= n - 10'd1;
                end
                RETRACT_LOADED: begin
                    if (load_tick && (n != 10'd0)) n <= n - 10'd1;
                end
                default: begin
                    n <= n;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tail position register, one cycle behind the step count.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            tailx <= ORIGIN_X;
            taily <= ORIGIN_Y;
        end else if (is_new_game_start) begin
            tailx <= ORIGIN_X;
            taily <= ORIGIN_Y;
        end else begin
            tailx <= cur_x[9:0];
            taily <= cur_y[9:0];
        end
    end

`ifdef HOOK_BOMB_EN
    // ------------------------------------------------------------------
    // Bomb stock and explode pulse. The object watching is_explode
    // destroys itself; the hook keeps its step count and finishes the
    // retract at empty speed.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            bomb_count <= 2'd2;
            is_explode <= 1'b0;
        end else if (is_new_game_start) begin
            bomb_count <= 2'd2;
            is_explode <= 1'b0;
        end else begin
            is_explode <= bomb_fire;
            if (bomb_fire) bomb_count <= bomb_count - 2'd1;
        end
    end
`endif

    assign state_out = state;
    assign busy      = (state != SWING);

endmodule

// File: tb/tb_hook_claw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hook_claw_ctrl
// Directed bench for hook_claw_ctrl with shortened dividers. A second
// instance with ORIGIN_X=30 exercises the left screen edge. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_hook_claw_ctrl;

    logic       Clk;
    logic       reset_n;
    logic       is_new_game_start;
    logic       fire;
    logic       is_catch;
    logic [9:0] tailx;
    logic [9:0] taily;
    logic [3:0] r_mode;
    logic [2:0] state_out;
    logic       score_pulse;
    logic       busy;

    logic       fire_e;
    logic       is_catch_e;
    logic [9:0] tailx_e;
    logic [9:0] taily_e;
    logic [3:0] r_mode_e;
    logic [2:0] state_e;
    logic       score_e;
    logic       busy_e;

`ifdef HOOK_BOMB_EN
    logic       use_bomb;
    logic       is_explode;
    logic       use_bomb_e;
    logic       is_explode_e;
`endif

    int vectors_applied = 0;
    int miscompares     = 0;

    int mr;
    int mdir;
    int mcnt;
    int cyc;
    logic [9:0] prev;

    hook_claw_ctrl #(
        .SWING_DIV (4),
        .STEP_DIV  (2),
        .LOAD_DIV  (8),
        .MAX_STEPS (10'd20)
    ) dut (
        .Clk               (Clk),
        .reset_n           (reset_n),
        .is_new_game_start (is_new_game_start),
        .fire              (fire),
        .is_catch          (is_catch),
`ifdef HOOK_BOMB_EN
        .use_bomb          (use_bomb),
        .is_explode        (is_explode),
`endif
        .tailx             (tailx),
        .taily             (taily),
        .R_mode            (r_mode),
        .state_out         (state_out),
        .score_pulse       (score_pulse),
        .busy              (busy)
    );

    hook_claw_ctrl #(
        .ORIGIN_X  (10'd30),
        .SWING_DIV (4),
        .STEP_DIV  (2),
        .LOAD_DIV  (8),
        .MAX_STEPS (10'd20)
    ) dut_e (
        .Clk               (Clk),
        .reset_n           (reset_n),
        .is_new_game_start (is_new_game_start),
        .fire              (fire_e),
        .is_catch          (is_catch_e),
`ifdef HOOK_BOMB_EN
        .use_bomb          (use_bomb_e),
        .is_explode        (is_explode_e),
`endif
        .tailx             (tailx_e),
        .taily             (taily_e),
        .R_mode            (r_mode_e),
        .state_out         (state_e),
        .score_pulse       (score_e),
        .busy              (busy_e)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case something upstream never returns.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors_applied++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, got, want);
        end
    endtask

    // Set the request inputs of the main instance, then let one edge pass.
    task automatic applyStimulus(input logic f, input logic c, input logic b);
        fire     = f;
        is_catch = c;
`ifdef HOOK_BOMB_EN
        use_bomb = b;
`endif
        @(negedge Clk);
        fire     = 1'b0;
        is_catch = 1'b0;
`ifdef HOOK_BOMB_EN
        use_bomb = 1'b0;
`endif
        if (b) begin
            mcnt = mcnt;
        end
    endtask

    function automatic logic [9:0] sig_of(input int which);
        case (which)
            0:       return tailx;
            1:       return taily;
            2:       return tailx_e;
            3:       return {7'd0, state_out};
            4:       return {7'd0, state_e};
            5:       return {6'd0, r_mode};
            default: return {6'd0, r_mode_e};
        endcase
    endfunction

    task automatic wait_change(input int which, input logic [9:0] old, input int limit, output int cycles);
        cycles = 0;
        while ((sig_of(which) == old) && (cycles < limit)) begin
            @(negedge Clk);
            cycles++;
        end
        checkOutput("wait_change", {31'd0, sig_of(which) != old}, 32'd1);
    endtask

    task automatic wait_equal(input int which, input logic [9:0] want, input int limit);
        int cycles;
        cycles = 0;
        while ((sig_of(which) != want) && (cycles < limit)) begin
            @(negedge Clk);
            cycles++;
        end
        checkOutput("wait_equal", {22'd0, sig_of(which)}, {22'd0, want});
    endtask

`ifdef HOOK_BOMB_EN
    int exp_explode [3] = '{1, 1, 0};
    int exp_state   [3] = '{2, 2, 3};
    int exp_rate    [3] = '{2, 2, 8};
`endif

    initial begin
        reset_n           = 1'b0;
        is_new_game_start = 1'b0;
        fire              = 1'b0;
        is_catch          = 1'b0;
        fire_e            = 1'b0;
        is_catch_e        = 1'b0;
`ifdef HOOK_BOMB_EN
        use_bomb          = 1'b0;
        use_bomb_e        = 1'b0;
`endif
        mcnt = 0;

        // Values held during reset.
        repeat (3) @(negedge Clk);
        checkOutput("rst_state", state_out, 0);
        checkOutput("rst_tailx", tailx, 320);
        checkOutput("rst_taily", taily, 60);
        checkOutput("rst_rmode", r_mode, 5);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_score", score_pulse, 0);
        checkOutput("rst_tailx_e", tailx_e, 30);
        reset_n = 1'b1;

        // Free-running swing: one index step every 4 clocks, ping-pong.
        mr = 5; mdir = 1; mcnt = 0;
        for (int k = 1; k <= 96; k++) begin
            @(negedge Clk);
            mcnt++;
            if (mcnt == 4) begin
                mcnt = 0;
                mr = (mdir == 1) ? mr + 1 : mr - 1;
                if (mr == 10) mdir = 0;
                if (mr == 0)  mdir = 1;
            end
            checkOutput("swing_rmode", r_mode, mr);
            checkOutput("swing_range", {31'd0, r_mode <= 4'd10}, 1);
        end
        checkOutput("swing_busy", busy, 0);

        // New game, then fire straight down.
        is_new_game_start = 1'b1;
        @(negedge Clk);
        is_new_game_start = 1'b0;
        checkOutput("ng_rmode", r_mode, 5);
        checkOutput("ng_state", state_out, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ext_state", state_out, 1);
        checkOutput("ext_busy", busy, 1);
        prev = taily;
        for (int k = 1; k <= 20; k++) begin
            wait_change(1, prev, 10, cyc);
            checkOutput("ext_y", taily, 60 + 6 * k);
            if (k > 1) checkOutput("ext_rate", cyc, 2);
            prev = taily;
        end
        checkOutput("ext_max_state", state_out, 2);
        checkOutput("ext_max_x", tailx, 320);
        for (int k = 19; k >= 0; k--) begin
            wait_change(1, prev, 10, cyc);
            checkOutput("ret_y", taily, 60 + 6 * k);
            if (k < 19) checkOutput("ret_rate", cyc, 2);
            prev = taily;
        end
        checkOutput("empty_return_state", state_out, 4);
        checkOutput("empty_return_score", score_pulse, 0);
        @(negedge Clk);
        checkOutput("empty_swing_state", state_out, 0);
        checkOutput("empty_swing_busy", busy, 0);
        checkOutput("empty_swing_score", score_pulse, 0);

        // Catch at n=10 pointing right, reel back at loaded speed.
        wait_equal(5, 10'd10, 40);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("catch_ext_state", state_out, 1);
        checkOutput("catch_frozen_r", r_mode, 10);
        prev = tailx;
        for (int k = 1; k <= 10; k++) begin
            wait_change(0, prev, 10, cyc);
            checkOutput("catch_ext_x", tailx, 320 + 6 * k);
            prev = tailx;
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("catch_state", state_out, 3);
        checkOutput("catch_hold_x", tailx, 380);
        checkOutput("catch_hold_y", taily, 60);
        for (int k = 9; k >= 0; k--) begin
            wait_change(0, prev, 12, cyc);
            checkOutput("load_x", tailx, 320 + 6 * k);
            if (k < 9) checkOutput("load_rate", cyc, 8);
            prev = tailx;
        end
        checkOutput("load_return_state", state_out, 4);
        checkOutput("load_return_score", score_pulse, 1);
        checkOutput("load_return_r", r_mode, 10);
        @(negedge Clk);
        checkOutput("load_score_end", score_pulse, 0);
        checkOutput("load_swing_state", state_out, 0);

        // Left edge: R_mode 0 from ORIGIN_X=30 stops at tailx 0 (n=5).
        is_new_game_start = 1'b1;
        @(negedge Clk);
        is_new_game_start = 1'b0;
        wait_equal(6, 10'd0, 80);
        fire_e = 1'b1;
        @(negedge Clk);
        fire_e = 1'b0;
        checkOutput("edge_ext_state", state_e, 1);
        prev = tailx_e;
        for (int k = 1; k <= 5; k++) begin
            wait_change(2, prev, 10, cyc);
            checkOutput("edge_x", tailx_e, 30 - 6 * k);
            prev = tailx_e;
        end
        checkOutput("edge_state", state_e, 2);
        checkOutput("edge_y", taily_e, 60);
        wait_change(2, prev, 10, cyc);
        checkOutput("edge_first_retract_x", tailx_e, 6);

        // Asynchronous reset in the middle of an extend (n=7).
        is_new_game_start = 1'b1;
        @(negedge Clk);
        is_new_game_start = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_equal(1, 10'd102, 30);
        checkOutput("pre_rst_state", state_out, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_state", state_out, 0);
        checkOutput("arst_tailx", tailx, 320);
        checkOutput("arst_taily", taily, 60);
        checkOutput("arst_rmode", r_mode, 5);
        checkOutput("arst_busy", busy, 0);
        @(negedge Clk);
        reset_n = 1'b1;

`ifdef HOOK_BOMB_EN
        // Three catches, each followed by a bomb request; only two bombs.
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            wait_equal(1, 10'd90, 30);
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("bomb_loaded_state", state_out, 3);
            repeat (2) @(negedge Clk);
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("bomb_explode", is_explode, exp_explode[b]);
            checkOutput("bomb_state", state_out, exp_state[b]);
            @(negedge Clk);
            checkOutput("bomb_pulse_end", is_explode, 0);
            prev = taily;
            wait_change(1, prev, 12, cyc);
            prev = taily;
            wait_change(1, prev, 12, cyc);
            checkOutput("bomb_rate", cyc, exp_rate[b]);
            wait_equal(3, 10'd0, 100);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
